// File: rtl/div4b_seq_pkg.sv
// Shared definitions for the sequential restoring divider:
// the default operand width and the control FSM state encoding.
package div_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div4b_seq_if.sv
// Handshake and operand/result bundle between the ALU control FSM (master)
// and the sequential divider (slave).
interface div4b_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_zero;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_zero
    );

endinterface

// File: rtl/div4b_seq_sub_nb.sv
// N-bit ripple subtractor built from full-subtractor cells, the mirror image
// of the team's ripple adder. diff = x - y (mod 2^N), bout = (x < y).
module sub_nb
    import div_pkg::*;
#(
    parameter int N = DIV_W + 1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    // One full-subtractor cell per bit; the borrow ripples from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]     = x[i] ^ y[i] ^ borrow[i];
        assign borrow[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow[i]);
    end

    assign bout = borrow[N];

endmodule

// File: rtl/div4b_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake toward the control FSM; Q/R/div_zero are held
// until the next completion.
// Optional feature macro: DIV_ZERO_DETECT_EN -- when defined, a zero divisor
// is detected at accept time and the result is produced without iterating.
module div4b_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic        clk,
    input  logic        rst_n,
    div4b_seq_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             bout;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;
    logic             zero_take;
    logic             unused_diff_msb;

    // The shifted partial remainder is one bit wider than the operands so the
    // bit shifted out of rem is never lost before the trial subtraction.
    assign rem_shift = {rem, dividend[WIDTH-1]};

    sub_nb #(.N(WIDTH + 1)) u_sub (
        .x    (rem_shift),
        .y    ({1'b0, divisor}),
        .diff (diff),
        .bout (bout)
    );

    // Without a borrow the difference is below the divisor, so its MSB is zero.
    assign unused_diff_msb = diff[WIDTH];
    assign rem_next        = bout ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next        = {quo[WIDTH-2:0], ~bout};
    assign last_iter       = (count == CW'(WIDTH - 1));

`ifdef DIV_ZERO_DETECT_EN
    assign zero_take = (bus.B == '0);
`else
    assign zero_take = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state = zero_take ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs: status decoded from the state, results from the held registers.
    always_comb begin
        bus.busy = (state == ST_RUN);
        bus.done = (state == ST_DONE);
        bus.Q    = q_reg;
        bus.R    = r_reg;
    end

    // Datapath: operand capture on accept, one shift-subtract step per RUN
    // cycle, and result load on the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        dividend <= bus.A;
                        divisor  <= bus.B;
                        rem      <= '0;
                        quo      <= '0;
                        count    <= '0;
                        if (zero_take) begin
                            q_reg <= '1;
                            r_reg <= bus.A;
                        end
                    end
                end
                ST_RUN: begin
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    rem      <= rem_next;
                    quo      <= quo_next;
                    count    <= count + 1'b1;
                    if (last_iter) begin
                        q_reg <= quo_next;
                        r_reg <= rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz_reg;

    // Divide-by-zero flag: set by the shortcut path, cleared by any normal
    // completion, otherwise held with Q/R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_reg <= 1'b0;
        end else if (state == ST_IDLE && bus.start && zero_take) begin
            dz_reg <= 1'b1;
        end else if (state == ST_RUN && last_iter) begin
            dz_reg <= 1'b0;
        end
    end

    assign bus.div_zero = dz_reg;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule
